// File: rtl/register_file_rw.sv
// Parametrised register file with independent write/read ports, registered read,
// per-cycle access checking and a saturating, clearable error counter.
module register_file_rw #(
  parameter int unsigned N      = 32,
  parameter int unsigned DEPTH  = 6,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned BYPASS = 0,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              writeEnable,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [N-1:0]      dataIn,
  input  logic              readEnable,
  input  logic [ADDR_W-1:0] readAddr,
  input  logic              clearErrors,
  output logic [N-1:0]      dataOut,
  output logic              readValid,
  output logic              accessError,
  output logic [CNT_W-1:0]  errorCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N-1:0] mem [DEPTH];

  logic         w_oor_c;
  logic         r_oor_c;
  logic         collision_c;
  logic         block_c;
  logic         err_c;
  logic         do_write_c;
  logic         do_read_c;
  logic [N-1:0] rdata_c;

  // Per-cycle access classification
  always_comb begin
    w_oor_c     = writeEnable && (32'(writeAddr) >= DEPTH);
    r_oor_c     = readEnable && (32'(readAddr) >= DEPTH);
    collision_c = writeEnable && readEnable && (writeAddr == readAddr) && !w_oor_c;
    block_c     = collision_c && (BYPASS == 0);
    err_c       = w_oor_c || r_oor_c || block_c;
    do_write_c  = writeEnable && !w_oor_c && !block_c;
    do_read_c   = readEnable && !r_oor_c && !block_c;
    rdata_c     = '0;
    if (do_read_c) begin
      // Only reachable with a collision when write-through forwarding is enabled
      rdata_c = collision_c ? dataIn : mem[readAddr];
    end
  end

  // Storage
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (do_write_c) begin
      mem[writeAddr] <= dataIn;
    end
  end

  // Read register and valid strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      dataOut   <= '0;
      readValid <= 1'b0;
    end else begin
      readValid <= do_read_c;
      if (do_read_c) begin
        dataOut <= rdata_c;
      end
    end
  end

  // Error pulse and saturating counter; a clear coinciding with an error leaves 1
  always_ff @(posedge clk) begin
    if (reset) begin
      accessError <= 1'b0;
      errorCount  <= '0;
    end else begin
      accessError <= err_c;
      if (clearErrors) begin
        errorCount <= CNT_W'(err_c);
      end else if (err_c && (errorCount != CNT_MAX)) begin
        errorCount <= errorCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_register_file_rw.sv
// Self-checking bench: two instances (collision drop / write-through) driven with the
// same directed and random stimulus, compared against a behavioural model.
module tb_register_file_rw;

  localparam int unsigned N     = 32;
  localparam int unsigned DEPTH = 6;
  localparam int unsigned AW    = 3;
  localparam int unsigned CW    = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          we;
  logic [AW-1:0] wa;
  logic [N-1:0]  din;
  logic          re;
  logic [AW-1:0] ra;
  logic          clr;

  logic [N-1:0]  dout0, dout1;
  logic          rv0, rv1, ae0, ae1;
  logic [CW-1:0] cnt0, cnt1;

  int tests = 0;
  int failed = 0;

  // Model state, index 0 = drop on collision, 1 = write-through
  logic [N-1:0] m_mem  [2][8];
  logic [N-1:0] m_dout [2];
  logic         m_rv   [2];
  logic         m_ae   [2];
  int           m_cnt  [2];

  always #5 clk = ~clk;

  register_file_rw #(.N(N), .DEPTH(DEPTH), .ADDR_W(AW), .BYPASS(0), .CNT_W(CW)) dut0 (
    .clk(clk), .reset(reset), .writeEnable(we), .writeAddr(wa), .dataIn(din),
    .readEnable(re), .readAddr(ra), .clearErrors(clr),
    .dataOut(dout0), .readValid(rv0), .accessError(ae0), .errorCount(cnt0)
  );

  register_file_rw #(.N(N), .DEPTH(DEPTH), .ADDR_W(AW), .BYPASS(1), .CNT_W(CW)) dut1 (
    .clk(clk), .reset(reset), .writeEnable(we), .writeAddr(wa), .dataIn(din),
    .readEnable(re), .readAddr(ra), .clearErrors(clr),
    .dataOut(dout1), .readValid(rv1), .accessError(ae1), .errorCount(cnt1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one edge of the specification's rules to the model
  task automatic model_edge();
    for (int b = 0; b < 2; b++) begin
      if (reset) begin
        for (int i = 0; i < 8; i++) m_mem[b][i] = '0;
        m_dout[b] = '0; m_rv[b] = 1'b0; m_ae[b] = 1'b0; m_cnt[b] = 0;
      end else begin
        bit woor, roor, coll, blk, err;
        woor = we && (int'(wa) >= int'(DEPTH));
        roor = re && (int'(ra) >= int'(DEPTH));
        coll = we && re && (wa == ra) && !woor;
        blk  = coll && (b == 0);
        err  = woor || roor || blk;
        m_rv[b] = re && !roor && !blk;
        if (m_rv[b]) m_dout[b] = coll ? din : m_mem[b][ra];
        if (we && !woor && !blk) m_mem[b][wa] = din;
        m_ae[b] = err;
        if (clr) m_cnt[b] = err ? 1 : 0;
        else if (err && m_cnt[b] < 255) m_cnt[b] = m_cnt[b] + 1;
      end
    end
  endtask

  task automatic step(input logic rst_i, input logic we_i, input logic [AW-1:0] wa_i,
                      input logic [N-1:0] din_i, input logic re_i, input logic [AW-1:0] ra_i,
                      input logic clr_i);
    reset = rst_i; we = we_i; wa = wa_i; din = din_i; re = re_i; ra = ra_i; clr = clr_i;
    @(posedge clk);
    model_edge();
    #1;
    check("dout0", 64'(dout0), 64'(m_dout[0]));
    check("rv0",   64'(rv0),   64'(m_rv[0]));
    check("ae0",   64'(ae0),   64'(m_ae[0]));
    check("cnt0",  64'(cnt0),  64'(m_cnt[0]));
    check("dout1", 64'(dout1), 64'(m_dout[1]));
    check("rv1",   64'(rv1),   64'(m_rv[1]));
    check("ae1",   64'(ae1),   64'(m_ae[1]));
    check("cnt1",  64'(cnt1),  64'(m_cnt[1]));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; wa = '0; din = '0; re = 1'b0; ra = '0; clr = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 8; i++) m_mem[b][i] = '0;
      m_dout[b] = '0; m_rv[b] = 1'b0; m_ae[b] = 1'b0; m_cnt[b] = 0;
    end

    // Reset with a write/read presented: both discarded
    step(1'b1, 1'b1, 3'd2, 32'h1234, 1'b1, 3'd2, 1'b0);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    check("rst_dout", 64'(dout0), 64'h0);
    check("rst_cnt",  64'(cnt0),  64'h0);

    // 1: write then read back
    step(1'b0, 1'b1, 3'd2, 32'hDEADBEEF, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 3'd2, 1'b0);
    check("t1_dout", 64'(dout0), 64'hDEADBEEF);
    check("t1_rv",   64'(rv0),   64'h1);
    check("t1_ae",   64'(ae0),   64'h0);
    idle();
    check("t1_rv_drop", 64'(rv0), 64'h0);
    check("t1_hold",    64'(dout0), 64'hDEADBEEF);

    // 2/3: same-address collision, old contents 0x5
    step(1'b0, 1'b1, 3'd1, 32'h5, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 3'd1, 32'h11, 1'b1, 3'd1, 1'b0);
    check("t2_rv",   64'(rv0),   64'h0);
    check("t2_hold", 64'(dout0), 64'hDEADBEEF);
    check("t2_ae",   64'(ae0),   64'h1);
    check("t2_cnt",  64'(cnt0),  64'h1);
    check("t3_dout", 64'(dout1), 64'h11);
    check("t3_rv",   64'(rv1),   64'h1);
    check("t3_ae",   64'(ae1),   64'h0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 3'd1, 1'b0);
    check("t2_mem",  64'(dout0), 64'h5);
    check("t3_mem",  64'(dout1), 64'h11);
    check("t2_ae_once", 64'(ae0), 64'h0);

    // 4: out-of-range write alongside an in-range read
    step(1'b0, 1'b1, 3'd0, 32'h7, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 3'd6, 32'h99, 1'b1, 3'd0, 1'b0);
    check("t4_dout", 64'(dout0), 64'h7);
    check("t4_rv",   64'(rv0),   64'h1);
    check("t4_ae",   64'(ae0),   64'h1);
    check("t4_cnt",  64'(cnt0),  64'h2);
    idle();
    check("t4_ae_once", 64'(ae0), 64'h0);

    // Independent ports: different addresses, read returns old contents
    step(1'b0, 1'b1, 3'd0, 32'hAB, 1'b1, 3'd2, 1'b0);
    check("ind_dout", 64'(dout0), 64'hDEADBEEF);
    check("ind_ae",   64'(ae0),   64'h0);

    // 5: saturation then clear together with an error, then clear alone
    for (int i = 0; i < 260; i++) step(1'b0, 1'b0, '0, '0, 1'b1, 3'd7, 1'b0);
    check("t5_sat0", 64'(cnt0), 64'd255);
    check("t5_sat1", 64'(cnt1), 64'd255);
    step(1'b0, 1'b0, '0, '0, 1'b1, 3'd6, 1'b1);
    check("t5_clr_err", 64'(cnt0), 64'd1);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    check("t5_clr", 64'(cnt0), 64'd0);

    // 6: read accepted, then reset; all entries read back as 0
    step(1'b0, 1'b0, '0, '0, 1'b1, 3'd2, 1'b0);
    check("t6_pre", 64'(dout0), 64'hDEADBEEF);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    check("t6_dout", 64'(dout0), 64'h0);
    check("t6_rv",   64'(rv0),   64'h0);
    for (int a = 0; a < int'(DEPTH); a++) begin
      step(1'b0, 1'b0, '0, '0, 1'b1, AW'(a), 1'b0);
      check("t6_mem", 64'(dout0), 64'h0);
    end

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom(),
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
           ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
